// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph table, segment constants and digit decode for the scan driver
package seg7_pkg;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_DRIVE = 1'b1
   } phase_e;

   localparam logic [7:0] SEG_OFF = 8'h00;

   // active-high gfedcba
   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h27;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   function automatic logic [6:0] seg7_decode(input logic [3:0] nibble, input logic hex);
      logic [6:0] g;
      case (nibble)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = hex ? GLYPH_A : 7'h00;
         4'hB:    g = hex ? GLYPH_B : 7'h00;
         4'hC:    g = hex ? GLYPH_C : 7'h00;
         4'hD:    g = hex ? GLYPH_D : 7'h00;
         4'hE:    g = hex ? GLYPH_E : 7'h00;
         default: g = hex ? GLYPH_F : 7'h00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational nibble-to-segment pattern, active-high {dp,g,f,e,d,c,b,a}
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex,
   input  logic       blank,
   input  logic       dp,
   output logic [7:0] pattern
);

   always_comb begin
      pattern = SEG_OFF;
      if (!blank) begin
         pattern = {dp, seg7_decode(nibble, hex)};
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit 7-segment scanner with blank interval
// and double-buffered display data.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int DWELL          = 1024,
   parameter int BLANK          = 16,
   parameter bit DIG_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                    CLK,
   input  logic                    CLR,
   input  logic [4*NUM_DIGITS-1:0] DIN,
   input  logic [NUM_DIGITS-1:0]   DP,
   input  logic [NUM_DIGITS-1:0]   BLANK_EN,
   input  logic                    HEX,
   input  logic                    LZS,
   input  logic                    LOAD,
   output logic                    PENDING,
   output logic [7:0]              SEG,
   output logic [NUM_DIGITS-1:0]   DIG,
   output logic                    FRAME
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [DW-1:0] BLANK_END  = DW'(BLANK);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [7:0]            SEG_INV = {8{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{DIG_ACTIVE_LOW}};

   logic [DW-1:0]           dwell_q, dwell_d;
   logic [IW-1:0]           idx_q, idx_d;

   logic [4*NUM_DIGITS-1:0] sh_din_q, sh_din_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic                    sh_hex_q, sh_hex_d;
   logic                    sh_lzs_q, sh_lzs_d;
   logic                    pending_q, pending_d;

   logic [4*NUM_DIGITS-1:0] act_din_q, act_din_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
   logic                    act_hex_q, act_hex_d;
   logic                    act_lzs_q, act_lzs_d;

   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   dig_q, dig_d;
   logic                    frame_q, frame_d;

   logic                    slot_end;
   logic                    boundary;
   phase_e                  phase;
   logic [3:0]              cur_nibble;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   supp;
   logic [7:0]              glyph_pat;
   logic [7:0]              drive_pat;
   logic [NUM_DIGITS-1:0]   dig_oh;

   // Leading-zero suppression: walk from the most significant digit until a
   // visible nonzero digit; blanked digits never end the leading run.
   always_comb begin
      logic seen_nz;
      logic nz;
      supp    = '0;
      seen_nz = 1'b0;
      nz      = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         nz = (act_din_q[4*k +: 4] != 4'h0) && !act_blank_q[k];
         if (act_lzs_q && !seen_nz && !nz && (k != 0)) begin
            supp[k] = 1'b1;
         end
         seen_nz = seen_nz | nz;
      end
   end

   assign cur_nibble = act_din_q[{idx_q, 2'b00} +: 4];
   assign cur_dp     = act_dp_q[idx_q];
   assign cur_blank  = act_blank_q[idx_q];

   seg7_glyph u_glyph (
      .nibble  (cur_nibble),
      .hex     (act_hex_q),
      .blank   (cur_blank),
      .dp      (cur_dp),
      .pattern (glyph_pat)
   );

   always_comb begin
      slot_end  = (dwell_q == DWELL_LAST);
      boundary  = slot_end && (idx_q == IDX_LAST);
      phase     = (dwell_q < BLANK_END) ? PH_BLANK : PH_DRIVE;

      dwell_d   = slot_end ? '0 : dwell_q + 1'b1;
      idx_d     = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      sh_din_d   = sh_din_q;
      sh_dp_d    = sh_dp_q;
      sh_blank_d = sh_blank_q;
      sh_hex_d   = sh_hex_q;
      sh_lzs_d   = sh_lzs_q;
      if (LOAD) begin
         sh_din_d   = DIN;
         sh_dp_d    = DP;
         sh_blank_d = BLANK_EN;
         sh_hex_d   = HEX;
         sh_lzs_d   = LZS;
      end

      act_din_d   = act_din_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      act_hex_d   = act_hex_q;
      act_lzs_d   = act_lzs_q;
      pending_d   = pending_q;
      // A LOAD landing on the boundary bypasses the shadow so it is never a frame late.
      if (boundary) begin
         pending_d = 1'b0;
         if (LOAD) begin
            act_din_d   = DIN;
            act_dp_d    = DP;
            act_blank_d = BLANK_EN;
            act_hex_d   = HEX;
            act_lzs_d   = LZS;
         end else if (pending_q) begin
            act_din_d   = sh_din_q;
            act_dp_d    = sh_dp_q;
            act_blank_d = sh_blank_q;
            act_hex_d   = sh_hex_q;
            act_lzs_d   = sh_lzs_q;
         end
      end else if (LOAD) begin
         pending_d = 1'b1;
      end

      drive_pat = glyph_pat & (supp[idx_q] ? 8'h80 : 8'hFF);
      dig_oh    = '0;
      if ((phase == PH_DRIVE) && !cur_blank) begin
         dig_oh = NUM_DIGITS'(1) << idx_q;
      end
      seg_d   = ((phase == PH_DRIVE) ? drive_pat : SEG_OFF) ^ SEG_INV;
      dig_d   = dig_oh ^ DIG_INV;
      frame_d = (idx_q == '0) && (dwell_q == '0);
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         dwell_q     <= '0;
         idx_q       <= '0;
         sh_din_q    <= '0;
         sh_dp_q     <= '0;
         sh_blank_q  <= '0;
         sh_hex_q    <= 1'b0;
         sh_lzs_q    <= 1'b0;
         pending_q   <= 1'b0;
         act_din_q   <= '0;
         act_dp_q    <= '0;
         act_blank_q <= '1;
         act_hex_q   <= 1'b0;
         act_lzs_q   <= 1'b0;
         seg_q       <= SEG_OFF ^ SEG_INV;
         dig_q       <= DIG_INV;
         frame_q     <= 1'b0;
      end else begin
         dwell_q     <= dwell_d;
         idx_q       <= idx_d;
         sh_din_q    <= sh_din_d;
         sh_dp_q     <= sh_dp_d;
         sh_blank_q  <= sh_blank_d;
         sh_hex_q    <= sh_hex_d;
         sh_lzs_q    <= sh_lzs_d;
         pending_q   <= pending_d;
         act_din_q   <= act_din_d;
         act_dp_q    <= act_dp_d;
         act_blank_q <= act_blank_d;
         act_hex_q   <= act_hex_d;
         act_lzs_q   <= act_lzs_d;
         seg_q       <= seg_d;
         dig_q       <= dig_d;
         frame_q     <= frame_d;
      end
   end

   assign PENDING = pending_q;
   assign SEG     = seg_q;
   assign DIG     = dig_q;
   assign FRAME   = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

   logic        clk;
   logic        clr;
   logic        load;
   logic        hex;
   logic        lzs;
   logic [15:0] din;
   logic [3:0]  dp;
   logic [3:0]  blank_en;
   logic        pending;
   logic [7:0]  seg;
   logic [3:0]  dig;
   logic        frame;
   logic        inv_pending;
   logic [7:0]  inv_seg;
   logic [3:0]  inv_dig;
   logic        inv_frame;

   int checks   = 0;
   int failures = 0;

   seg7_scan_driver #(
      .NUM_DIGITS(4), .DWELL(8), .BLANK(2), .DIG_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
   ) u_dut (
      .CLK(clk), .CLR(clr), .DIN(din), .DP(dp), .BLANK_EN(blank_en), .HEX(hex),
      .LZS(lzs), .LOAD(load), .PENDING(pending), .SEG(seg), .DIG(dig), .FRAME(frame)
   );

   seg7_scan_driver #(
      .NUM_DIGITS(4), .DWELL(8), .BLANK(2), .DIG_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b1)
   ) u_inv (
      .CLK(clk), .CLR(clr), .DIN(din), .DP(dp), .BLANK_EN(blank_en), .HEX(hex),
      .LZS(lzs), .LOAD(load), .PENDING(inv_pending), .SEG(inv_seg), .DIG(inv_dig),
      .FRAME(inv_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame();
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (frame === 1'b1) found = 1'b1;
      end
      chk("frame_wait", 32'(found), 32'd1);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                          input logic h, input logic l);
      din = d; dp = p; blank_en = b; hex = h; lzs = l;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   // Called right after a FRAME sample; walks the rest of that frame.
   task automatic check_frame(input string tag, input logic [31:0] segs,
                              input logic [15:0] digs, input logic [3:0] dcare);
      chk($sformatf("%s_seg_m0", tag), 32'(seg), 32'h00);
      for (int m = 1; m < 32; m++) begin
         int slot;
         int dw;
         logic [7:0] es;
         logic [3:0] ed;
         tick();
         slot = m / 8;
         dw   = m % 8;
         es   = segs[slot*8 +: 8];
         ed   = digs[slot*4 +: 4];
         chk($sformatf("%s_frame_m%0d", tag, m), 32'(frame), 32'd0);
         chk($sformatf("%s_pend_m%0d", tag, m), 32'(pending), 32'd0);
         if (dw < 2) begin
            chk($sformatf("%s_bseg_m%0d", tag, m), 32'(seg), 32'h00);
            chk($sformatf("%s_bdig_m%0d", tag, m), 32'(dig), 32'hF);
         end else begin
            chk($sformatf("%s_seg_m%0d", tag, m), 32'(seg), 32'(es));
            if (dcare[slot]) chk($sformatf("%s_dig_m%0d", tag, m), 32'(dig), 32'(ed));
         end
      end
   endtask

   initial begin
      clr = 1'b1; load = 1'b0; hex = 1'b0; lzs = 1'b0;
      din = '0; dp = '0; blank_en = '0;

      // reset state
      tick(); tick();
      chk("rst_seg", 32'(seg), 32'h00);
      chk("rst_dig", 32'(dig), 32'hF);
      chk("rst_frame", 32'(frame), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_inv_seg", 32'(inv_seg), 32'hFF);
      chk("rst_inv_dig", 32'(inv_dig), 32'h0);
      chk("rst_inv_frame", 32'(inv_frame), 32'd0);
      chk("rst_inv_pending", 32'(inv_pending), 32'd0);
      clr = 1'b0;

      // dark display, FRAME every 32 cycles
      for (int i = 0; i < 64; i++) begin
         tick();
         chk($sformatf("idle_frame_%0d", i), 32'(frame), 32'((i % 32) == 0));
         chk($sformatf("idle_seg_%0d", i), 32'(seg), 32'h00);
         chk($sformatf("idle_dig_%0d", i), 32'(dig), 32'hF);
         chk($sformatf("idle_pend_%0d", i), 32'(pending), 32'd0);
      end

      // 0x1234 decimal
      wait_frame(); tick(); tick(); tick();
      do_load(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0);
      chk("t2_pending", 32'(pending), 32'd1);
      wait_frame();
      check_frame("t2", 32'h065B4F66, 16'h7BDE, 4'hF);

      // hex with LZS and DP on a suppressed digit
      wait_frame(); tick(); tick(); tick();
      do_load(16'h00A5, 4'b0100, 4'b0000, 1'b1, 1'b1);
      chk("t3_pending", 32'(pending), 32'd1);
      wait_frame();
      check_frame("t3hex", 32'h0080776D, 16'h7BDE, 4'h7);
      wait_frame(); tick(); tick(); tick();
      do_load(16'h00A5, 4'b0100, 4'b0000, 1'b0, 1'b1);
      wait_frame();
      check_frame("t3dec", 32'h0080006D, 16'h7BDE, 4'h5);

      // remaining letters
      wait_frame(); tick(); tick(); tick();
      do_load(16'hFEDC, 4'b0000, 4'b0000, 1'b1, 1'b0);
      wait_frame();
      check_frame("letters", 32'h71795E39, 16'h7BDE, 4'hF);

      // last LOAD within a frame wins
      wait_frame(); tick(); tick(); tick();
      do_load(16'h1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
      chk("t4_pend_a", 32'(pending), 32'd1);
      repeat (10) tick();
      do_load(16'h2222, 4'b0000, 4'b0000, 1'b0, 1'b0);
      chk("t4_pend_b", 32'(pending), 32'd1);
      wait_frame();
      check_frame("t4last", 32'h5B5B5B5B, 16'h7BDE, 4'hF);

      // LOAD on the boundary cycle goes straight to active
      wait_frame();
      repeat (30) tick();
      do_load(16'h3333, 4'b0000, 4'b0000, 1'b0, 1'b0);
      chk("t4_bnd_pend", 32'(pending), 32'd0);
      wait_frame();
      check_frame("t4bnd", 32'h4F4F4F4F, 16'h7BDE, 4'hF);

      // CLR mid slot 2 with a transfer still pending
      wait_frame();
      repeat (5) tick();
      do_load(16'h4444, 4'b0000, 4'b0000, 1'b0, 1'b0);
      repeat (13) tick();
      chk("t5_pend_pre", 32'(pending), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t5_clr_seg", 32'(seg), 32'h00);
      chk("t5_clr_dig", 32'(dig), 32'hF);
      chk("t5_clr_frame", 32'(frame), 32'd0);
      chk("t5_clr_pend", 32'(pending), 32'd0);
      tick();
      chk("t5_first_frame", 32'(frame), 32'd1);
      check_frame("t5dark0", 32'h00000000, 16'hFFFF, 4'hF);
      wait_frame();
      check_frame("t5dark1", 32'h00000000, 16'hFFFF, 4'hF);

      // LZS: digit 0 never suppressed, DP on digit 0
      wait_frame(); tick(); tick(); tick();
      do_load(16'h0090, 4'b0001, 4'b0000, 1'b0, 1'b1);
      wait_frame();
      check_frame("lzs0", 32'h00006FBF, 16'h7BDE, 4'h3);

      // a blanked top digit is dark (DP too) and does not end the leading-zero run
      wait_frame(); tick(); tick(); tick();
      do_load(16'h5030, 4'b1000, 4'b1000, 1'b0, 1'b1);
      wait_frame();
      check_frame("lzsblk", 32'h00004F3F, 16'hFBDE, 4'hB);

      // inverted-polarity instance
      wait_frame(); tick(); tick(); tick();
      do_load(16'h8888, 4'b0000, 4'b0000, 1'b0, 1'b0);
      wait_frame();
      chk("t6_inv_seg_m0", 32'(inv_seg), 32'hFF);
      chk("t6_inv_dig_m0", 32'(inv_dig), 32'h0);
      for (int m = 1; m < 32; m++) begin
         int slot;
         int dw;
         logic [3:0] oh;
         tick();
         slot = m / 8;
         dw   = m % 8;
         oh   = 4'b0001 << slot;
         if (dw < 2) begin
            chk($sformatf("t6_bseg_m%0d", m), 32'(inv_seg), 32'hFF);
            chk($sformatf("t6_bdig_m%0d", m), 32'(inv_dig), 32'h0);
         end else begin
            chk($sformatf("t6_seg_m%0d", m), 32'(inv_seg), 32'h80);
            chk($sformatf("t6_dig_m%0d", m), 32'(inv_dig), 32'(oh));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
